regfile_dump_ctrl: RTL and testbench

//  Sequencer for the register file's external read port (reg_rd_en/reg_addr/reg_data).
//  On a start pulse it sweeps a register range, reads one register at a time and streams
//  {addr,data} out over a valid/ready interface. Used by the debug/status path to dump

---
 rtl/regfile_dump_ctrl.sv | 106 ++++++++++
 tb/tb_regfile_dump_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: sweeps a register range through the register file's external read port and streams {addr,data} beats over valid/ready
//   clk, rst_n                   clock, synchronous active-low reset
//   start, first_addr, last_addr sweep request and inclusive range (taken only in IDLE)
//   abort                        terminate a sweep in progress
//   busy, done, aborted          status: active, completed pulse, aborted pulse
//   reg_rd_en, reg_addr, reg_data register file read port (data one cycle after enable)
//   m_valid, m_ready, m_addr, m_data, m_last  output beat stream
module regfile_dump_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEND} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d, last_q, last_d, m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d, done_q, done_d, aborted_q, aborted_d;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        if (state_q != IDLE && abort) begin
            // abort beats a simultaneous handshake: no done, cur left as last issued
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    cur_d   = first_addr;
                    last_d  = last_addr;
                    state_d = ISSUE;
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    m_data_d = reg_data;
                    m_addr_d = cur_q;
                    m_last_d = cur_q == last_q;
                    state_d  = SEND;
                end
                SEND: if (m_ready) begin
                    // index wraps naturally at ADDR_W bits, so first>last sweeps through 0
                    done_d  = m_last_q;
                    cur_d   = m_last_q ? cur_q : cur_q + 1'b1;
                    state_d = m_last_q ? IDLE : ISSUE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            last_q    <= '0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            m_addr_q  <= m_addr_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // cur only changes when a new read is about to issue, so it doubles as the held read address
    assign busy      = state_q != IDLE;
    assign reg_rd_en = state_q == ISSUE;
    assign reg_addr  = cur_q;
    assign m_valid   = state_q == SEND;
    assign m_addr    = m_addr_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: directed scoreboard bench for regfile_dump_ctrl
module tb_regfile_dump_ctrl;
    logic        clk = 0, rst_n = 0, start = 0, abort = 0, m_ready = 1;
    logic [4:0]  first_addr = 0, last_addr = 0, reg_addr, m_addr;
    logic [31:0] reg_data = 0, m_data;
    logic        busy, done, aborted, reg_rd_en, m_valid, m_last;
    logic [31:0] regs [32];
    typedef struct packed {logic [4:0] a; logic [31:0] d; logic l;} beat_t;
    beat_t q[$];
    int vec = 0, errs = 0;

    regfile_dump_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_data(reg_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_addr(m_addr), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (reg_rd_en) reg_data <= regs[reg_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one sweep; the expected beats are queued up front, and a phase model
    // (0 idle, 1 issue, 2 wait, 3 send) checks every cycle until the return to idle.
    task automatic sweep(input int f, input int l, input int hold_a, input int abort_a, input bit poke);
        int n, ph, ph_n, k, held;
        bit exp_done, exp_ab, fin, hs;
        logic [4:0] a;
        n = ((l - f) & 31) + 1;
        for (int i = 0; i < n; i++) begin
            a = 5'(f + i);
            q.push_back('{a, regs[a], i == n - 1});
        end
        first_addr = 5'(f); last_addr = 5'(l); start = 1; abort = poke;
        ph_n = 1; k = 0; held = 0; exp_done = 0; exp_ab = 0; fin = 0;
        for (int t = 0; t < 400 && !fin; t++) begin
            @(negedge clk);
            k++; ph = ph_n;
            chk("busy", busy, ph != 0);
            chk("rd_en", reg_rd_en, ph == 1);
            chk("m_valid", m_valid, ph == 3);
            chk("done", done, exp_done);
            chk("aborted", aborted, exp_ab);
            if (ph == 1) chk("reg_addr", reg_addr, q[0].a);
            if (ph == 3) chk("beat", {m_addr, m_data, m_last}, q[0]);
            if (ph == 0) begin
                if (exp_done && hold_a < 0) chk("done_cycle", k, 3 * n + 1);
                fin = 1;
            end else begin
                start = poke;
                if (poke) begin first_addr = 5'($urandom); last_addr = 5'($urandom); end
                m_ready = !(ph == 3 && int'(q[0].a) == hold_a && held < 10);
                if (!m_ready) held++;
                abort = ph == 3 && int'(q[0].a) == abort_a;
                hs = ph == 3 && m_ready;
                exp_done = 0; exp_ab = 0;
                if (abort) begin
                    ph_n = 0; exp_ab = 1;
                    if (hs) void'(q.pop_front());
                end else if (ph == 1) ph_n = 2;
                else if (ph == 2) ph_n = 3;
                else if (hs) begin
                    exp_done = q[0].l;
                    ph_n = q[0].l ? 0 : 1;
                    void'(q.pop_front());
                end
            end
        end
        start = 0; abort = 0; m_ready = 1;
        if (!fin) begin
            vec++; errs++;
            $error("FAIL timeout: sweep %0d..%0d still busy, required idle", f, l);
        end
        if (abort_a >= 0) begin
            chk("abort_left", q.size(), 31 - abort_a);
            q.delete();
        end
        chk("q_empty", q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {busy, done, aborted, reg_rd_en, m_valid, m_last, reg_addr, m_addr, m_data}, 0);
        rst_n = 1;
        @(negedge clk);
        regs[5] = 32'hDEAD_BEEF;
        sweep(5, 5, -1, -1, 0);
        for (int i = 0; i < 32; i++) regs[i] = i * 32'h11;
        sweep(0, 31, -1, -1, 0);
        sweep(30, 1, -1, -1, 0);
        sweep(2, 5, 3, -1, 0);
        sweep(0, 31, -1, 7, 0);
        sweep(5, 5, -1, -1, 0);
        sweep(8, 12, -1, -1, 1);
        first_addr = 0; last_addr = 31; start = 1; m_ready = 0;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", m_valid, 1);
        rst_n = 0;
        @(negedge clk);
        chk("mid_rst_outs", {busy, done, aborted, reg_rd_en, m_valid, m_last, reg_addr, m_addr, m_data}, 0);
        rst_n = 1; m_ready = 1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", {busy, done, m_valid}, 0);
        end
        sweep(30, 1, -1, -1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
